dcache: RTL

Direct-mapped, write-through, write-no-allocate data cache between the memory pipeline stage and the backing data RAM. It serves loads in the same cycle on a hit. On a read miss or any store, it stalls the pipeline while a handshaked transaction to backing memory completes. It replaces the direct memory-stage-to-RAM connection in the pipelined core.

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_store.sv | 49 ++++
 rtl/dcache.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_SB  = 3'b000;

   localparam int unsigned BYTES = 4;

   typedef struct packed {
      logic [BYTES-1:0] be;
      logic [31:0]      data;
   } store_lane_t;

   // Byte enables and lane-shifted data for a store; non-SB sizes act as a full word.
   function automatic store_lane_t store_lane(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] wdata);
      store_lane_t r;
      if (f3 == F3_SB) begin
         r.be   = 4'b0001 << off;
         r.data = {24'h0, wdata[7:0]} << {off, 3'b000};
      end else begin
         r.be   = 4'hF;
         r.data = wdata;
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: combinational read, byte-enabled synchronous write, valid clear on rst.
module dcache_store
   import dcache_pkg::*;
#(
   parameter int unsigned SETS       = 8,
   parameter int unsigned TAG_W      = 27,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(SETS)-1:0]  idx_i,
   output logic                     valid_o,
   output logic [TAG_W-1:0]         tag_o,
   output logic [DATA_WIDTH-1:0]    data_o,
   input  logic                     we_i,
   input  logic [TAG_W-1:0]         tag_i,
   input  logic [DATA_WIDTH-1:0]    data_i,
   input  logic [BYTES-1:0]         be_i
);

   logic [SETS-1:0]       valid_q;
   logic [TAG_W-1:0]      tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS];

   assign valid_o = valid_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign data_o  = data_q[idx_i];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   // Reset suppresses any line update that coincides with it.
   always_ff @(posedge clk) begin
      if (we_i && !rst) begin
         tag_q[idx_i] <= tag_i;
         for (int b = 0; b < int'(BYTES); b++) begin
            if (be_i[b]) begin
               data_q[idx_i][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of the data RAM.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise they read as zero.
module dcache
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned SETS       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Func3M,
   input  logic [ADDR_WIDTH-1:0] AddrM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int unsigned IW = $clog2(SETS);
   localparam int unsigned TW = ADDR_WIDTH - IW - 2;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            f3_q, f3_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic                  req_q, we_q;

   logic [ADDR_WIDTH-1:0] lk_addr;
   logic [2:0]            lk_f3;
   logic                  line_valid, hit;
   logic [TW-1:0]         line_tag;
   logic [DATA_WIDTH-1:0] line_data;
   logic [7:0]            line_byte;
   logic                  st_we;
   logic [DATA_WIDTH-1:0] st_data;
   logic [3:0]            st_be;
   store_lane_t           lane;

   // Live request in IDLE; the latched request once a transaction has started.
   assign lk_addr = (state_q == IDLE) ? AddrM : addr_q;
   assign lk_f3   = (state_q == IDLE) ? Func3M : f3_q;
   assign hit     = line_valid && (line_tag == lk_addr[ADDR_WIDTH-1:IW+2]);

   dcache_store #(
      .SETS       (SETS),
      .TAG_W      (TW),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .idx_i   (lk_addr[IW+1:2]),
      .valid_o (line_valid),
      .tag_o   (line_tag),
      .data_o  (line_data),
      .we_i    (st_we),
      .tag_i   (addr_q[ADDR_WIDTH-1:IW+2]),
      .data_i  (st_data),
      .be_i    (st_be)
   );

   assign line_byte = line_data[{lk_addr[1:0], 3'b000} +: 8];
   assign ReadDataM = (lk_f3 == F3_LBU) ? DATA_WIDTH'(line_byte) : line_data;

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      StallM  = 1'b0;
      st_we   = 1'b0;
      st_data = mem_rdata;
      st_be   = 4'hF;
      lane    = store_lane(Func3M, AddrM[1:0], WriteDataM);
      case (state_q)
         IDLE: begin
            if (MemWriteM) begin
               StallM  = 1'b1;
               state_d = WRITE;
               addr_d  = AddrM;
               f3_d    = Func3M;
               wdata_d = lane.data;
               be_d    = lane.be;
            end else if (MemReadM && !hit) begin
               StallM  = 1'b1;
               state_d = FILL;
               addr_d  = AddrM;
               f3_d    = Func3M;
               wdata_d = '0;
               be_d    = 4'hF;
            end
         end
         FILL: begin
            StallM = 1'b1;
            if (mem_ack) begin
               st_we   = 1'b1;
               state_d = DONE;
            end
         end
         WRITE: begin
            StallM = 1'b1;
            if (mem_ack) begin
               st_we   = hit;
               st_data = wdata_q;
               st_be   = be_q;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         f3_q    <= F3_LW;
         wdata_q <= '0;
         be_q    <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         req_q   <= (state_d == FILL) || (state_d == WRITE);
         we_q    <= (state_d == WRITE);
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if ((state_q == IDLE) && MemReadM && !MemWriteM && hit) begin
            hit_q <= hit_q + 32'd1;
         end
         if ((state_q == IDLE) && (state_d == FILL)) begin
            miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule
